rr_arbiter_8to3: RTL
====================

// Module: rr_arbiter_8to3
// PURPOSE
//  Round-robin arbiter that shares one downstream resource (e.g. the 8-to-3 encoded
//  select path) among N requesters. Emits a one-hot grant plus its binary index.
//  Grants are registered, held while the owner keeps requesting, and bounded by a
//  hold limit. Sits between requesting engines and the shared datapath select.
// PARAMETERS
//  N        8   number of requesters (>=2)
//  IDX_W    3   index width, = $clog2(N)
//  MAX_HOLD 16  max consecutive grant cycles when others wait; 0 = unlimited
// PORTS
//  clk          in   1      rising-edge clock, single clock domain
//  rst_n        in   1      asynchronous reset, active-low
//  en           in   1      arbiter enable; low = drop grant, no new grants
//  req          in   N      request vector, bit i = requester i
//  gnt          out  N      one-hot grant, registered
//  gnt_idx      out  IDX_W  binary index of granted requester (0 when !gnt_valid)
//  gnt_valid    out  1      high whenever gnt is non-zero
//  hold_expired out  1      1-cycle pulse when a grant is force-released by MAX_HOLD
// BEHAVIOUR
//  Reset (async, rst_n=0): gnt=0, gnt_idx=0, gnt_valid=0, hold_expired=0,
//   ptr=0 (req[0] highest priority), hold_cnt=0, state=IDLE. Outputs clear immediately,
//   including mid-grant; arbitration restarts from ptr=0 after rst_n rises.
//  States: IDLE, GRANT.
//  IDLE: if en && |req -> pick first set bit scanning ptr, ptr+1, ... wrapping N-1->0;
//   next edge: gnt=onehot(k), gnt_idx=k, gnt_valid=1, hold_cnt=1, state=GRANT.
//   Latency req->gnt = 1 cycle. Otherwise outputs stay 0.
//  GRANT, each edge, priority order:
//   1) !en or !req[gnt_idx] -> release: outputs 0, ptr=(gnt_idx+1) mod N, IDLE.
//   2) MAX_HOLD!=0 && hold_cnt==MAX_HOLD && |(req & ~gnt) -> forced release: as (1),
//      plus hold_expired=1 for exactly that cycle.
//   3) else keep grant; hold_cnt increments, saturating at MAX_HOLD (no wrap).
//  No other requester waiting -> owner keeps grant indefinitely (no expiry).
//  Every release inserts exactly one IDLE bubble cycle; no back-to-back grants.
//  Requests arriving during GRANT are ignored until the next IDLE evaluation.
//  Request bits may drop/raise at any time; only req[gnt_idx] affects a held grant.
//  ptr only changes on release; wrap 7->0 via mod N (N need not be power of 2:
//   (N-1)+1 -> 0).
//  Invariants: gnt is $onehot0; gnt_valid == |gnt; gnt_idx == encode(gnt).
// STRUCTURE
//  Shared package arb_pkg: state enum {IDLE, GRANT}, clog2 helper, default
//   MAX_HOLD constant.
//  Sub-module arb_prio_encoder: combinational rotating priority encoder
//   (req, ptr) -> (found, idx); mask-and-double-vector scheme, 8-to-3 encode at core.
//  Top holds FSM, ptr, hold_cnt, output registers; all flops on posedge clk /
//   negedge rst_n.
// TESTING
//  1 reset: rst_n=0 with req=8'hFF -> gnt=0, gnt_idx=0, gnt_valid=0 every cycle.
//  2 single req: en=1, req=8'h10 at cycle c -> gnt=8'h10, gnt_idx=4 at c+1;
//    req drops -> gnt=0 next cycle.
//  3 rotation: req=8'hFF, each owner drops req for 1 cycle after grant -> grant order
//    0,1,2..7,0 (wrap), one bubble between each.
//  4 hold limit: req=8'h03, owner 0 holds -> after 16 grant cycles forced release,
//    hold_expired=1 one cycle, then gnt=8'h02.
//  5 no contention: req=8'h01 only for 100 cycles -> gnt held all cycles,
//    hold_expired never 1.
//  6 en/reset mid-grant: en=0 during grant -> gnt=0 next cycle, no new grant while
//    en=0; rst_n pulse mid-grant -> gnt=0 immediately, next grant honours ptr=0.
//  Assertions: $onehot0(gnt), gnt_valid==|gnt, gnt_idx matches gnt, on every cycle.

Source files
------------

// File: rtl/rr_arbiter_8to3_pkg.sv
// Shared constants for the round-robin arbiter: FSM state encodings, default hold limit
// and a constant-evaluable log2 helper.
package rr_arbiter_8to3_pkg;

    localparam int unsigned DefaultMaxHold = 16;

    localparam logic StIdle  = 1'b0;
    localparam logic StGrant = 1'b1;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) r++;
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter_8to3_if.sv
// Request/grant bundle between the requesting engines (master) and the arbiter (slave).
interface rr_arbiter_8to3_if
    import rr_arbiter_8to3_pkg::*;
#(
    parameter int unsigned N     = 8,
    parameter int unsigned IDX_W = clog2(N)
);
    logic             en;
    logic [N-1:0]     req;
    logic [N-1:0]     gnt;
    logic [IDX_W-1:0] gnt_idx;
    logic             gnt_valid;
    logic             hold_expired;

    modport master (
        output en, req,
        input  gnt, gnt_idx, gnt_valid, hold_expired
    );

    modport slave (
        input  en, req,
        output gnt, gnt_idx, gnt_valid, hold_expired
    );
endinterface

// File: rtl/rr_arbiter_8to3_prio_enc.sv
// Rotating priority encoder: first set request at or after ptr, wrapping N-1 -> 0.
// Uses the mask-and-double trick so the search is a plain lowest-set-bit encode.
module rr_arbiter_8to3_prio_enc
    import rr_arbiter_8to3_pkg::*;
#(
    parameter int unsigned N     = 8,
    parameter int unsigned IDX_W = clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic             found,
    output logic [IDX_W-1:0] idx
);
    logic [N-1:0]   masked;
    logic [2*N-1:0] dbl;
    logic [IDX_W:0] pos;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            masked[i] = req[i] && (i >= int'(ptr));
        end
        // Lower half holds requests at/after ptr; upper half supplies the wrapped ones.
        dbl   = {req, masked};
        found = 1'b0;
        pos   = '0;
        for (int i = 2 * N - 1; i >= 0; i--) begin
            if (dbl[i]) begin
                found = 1'b1;
                pos   = (IDX_W + 1)'(i);
            end
        end
        idx = (pos >= (IDX_W + 1)'(N)) ? IDX_W'(pos - (IDX_W + 1)'(N)) : IDX_W'(pos);
    end

endmodule

// File: rtl/rr_arbiter_8to3.sv
// Registered round-robin arbiter with grant hold and a bounded hold time when others wait.
module rr_arbiter_8to3
    import rr_arbiter_8to3_pkg::*;
#(
    parameter int unsigned N        = 8,
    parameter int unsigned IDX_W    = clog2(N),
    parameter int unsigned MAX_HOLD = DefaultMaxHold
) (
    input logic                 clk,
    input logic                 rst_n,
    rr_arbiter_8to3_if.slave    bus
);
    localparam int unsigned HoldW = (MAX_HOLD > 0) ? clog2(MAX_HOLD + 1) : 1;

    logic             state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [N-1:0]     gnt_q, gnt_d;
    logic [HoldW-1:0] hold_q, hold_d;
    logic             exp_q, exp_d;

    logic             found;
    logic [IDX_W-1:0] pick;
    logic             drop, expire, hold_at_max;

    rr_arbiter_8to3_prio_enc #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_prio_enc (
        .req   (bus.req),
        .ptr   (ptr_q),
        .found (found),
        .idx   (pick)
    );

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        idx_d       = idx_q;
        gnt_d       = gnt_q;
        hold_d      = hold_q;
        exp_d       = 1'b0;
        hold_at_max = (MAX_HOLD != 0) && (hold_q == HoldW'(MAX_HOLD));
        drop        = !bus.en || !bus.req[idx_q];
        expire      = hold_at_max && |(bus.req & ~gnt_q);

        case (state_q)
            StIdle: begin
                if (bus.en && found) begin
                    state_d = StGrant;
                    gnt_d   = {{(N - 1){1'b0}}, 1'b1} << pick;
                    idx_d   = pick;
                    hold_d  = HoldW'(1);
                end else begin
                    gnt_d = '0;
                    idx_d = '0;
                end
            end
            default: begin
                if (drop || expire) begin
                    // Release always passes priority to the next index, even on a forced release.
                    state_d = StIdle;
                    gnt_d   = '0;
                    idx_d   = '0;
                    hold_d  = '0;
                    exp_d   = !drop;
                    ptr_d   = (idx_q == IDX_W'(N - 1)) ? '0 : idx_q + 1'b1;
                end else if ((MAX_HOLD != 0) && !hold_at_max) begin
                    hold_d = hold_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            idx_q   <= '0;
            gnt_q   <= '0;
            hold_q  <= '0;
            exp_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            gnt_q   <= gnt_d;
            hold_q  <= hold_d;
            exp_q   <= exp_d;
        end
    end

    assign bus.gnt          = gnt_q;
    assign bus.gnt_idx      = idx_q;
    assign bus.gnt_valid    = |gnt_q;
    assign bus.hold_expired = exp_q;

endmodule
